// File: rtl/dbg_abscmd_encoder.sv
// Abstract-command encoder: turns one DMI access-register command into a short
// sequence of CSR instructions fed to the fetch path, and reports completion after retire.
module dbg_abscmd_encoder #(
  parameter logic [11:0] DSCRATCH0_ADDR  = 12'h7B2,
  parameter logic [11:0] DSCRATCH1_ADDR  = 12'h7B3,
  parameter logic [4:0]  TMP_REG         = 5'd8,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        halted_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [15:0] cmd_regno_i,
  input  logic        cmd_write_i,
  input  logic        cmd_transfer_i,
  input  logic [2:0]  cmd_aarsize_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  input  logic        inst_retire_i,
  output logic        done_o,
  output logic [2:0]  cmderr_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

  localparam logic [2:0] MAX_OUT = 3'(MAX_OUTSTANDING);

  state_t      state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic [2:0]  outst_q, outst_d;
  logic [2:0]  err_q, err_d;
  logic [31:0] inst_q, inst_d;
  logic        done_q;
  logic [2:0]  cmderr_q;
  logic        is_csr_q, write_q;
  logic [11:0] regno_q;

  logic accept, hs, retire_eff, last_step, cmd_is_csr, cmd_is_gpr;

  function automatic logic [31:0] csrrw(input logic [11:0] csr, input logic [4:0] rs1,
                                        input logic [4:0] rd);
    return {csr, rs1, 3'b001, rd, 7'h73};
  endfunction

  function automatic logic [31:0] csrrs(input logic [11:0] csr, input logic [4:0] rs1,
                                        input logic [4:0] rd);
    return {csr, rs1, 3'b010, rd, 7'h73};
  endfunction

  // CSR access goes through TMP_REG, which is parked in dscratch1 around the transfer.
  function automatic logic [31:0] encode(input logic is_csr, input logic write,
                                         input logic [11:0] regno, input logic [1:0] step);
    if (!is_csr)
      return write ? csrrs(DSCRATCH0_ADDR, 5'd0, regno[4:0])
                   : csrrw(DSCRATCH0_ADDR, regno[4:0], 5'd0);
    case (step)
      2'd0:    return csrrw(DSCRATCH1_ADDR, TMP_REG, 5'd0);
      2'd1:    return write ? csrrs(DSCRATCH0_ADDR, 5'd0, TMP_REG)
                            : csrrs(regno, 5'd0, TMP_REG);
      2'd2:    return write ? csrrw(regno, TMP_REG, 5'd0)
                            : csrrw(DSCRATCH0_ADDR, TMP_REG, 5'd0);
      default: return csrrs(DSCRATCH1_ADDR, 5'd0, TMP_REG);
    endcase
  endfunction

  assign cmd_ready_o  = (state_q == IDLE);
  assign inst_valid_o = (state_q == ISSUE) && (outst_q < MAX_OUT);
  assign inst_o       = inst_q;
  assign done_o       = done_q;
  assign cmderr_o     = cmderr_q;

  assign accept     = cmd_valid_i && cmd_ready_o;
  assign hs         = inst_valid_o && inst_ready_i;
  assign retire_eff = inst_retire_i && (outst_q != 3'd0);
  assign last_step  = is_csr_q ? (step_q == 2'd3) : (step_q == 2'd0);
  assign cmd_is_csr = (cmd_regno_i[15:12] == 4'h0);
  assign cmd_is_gpr = (cmd_regno_i[15:5] == 11'h080);
  assign outst_d    = outst_q + {2'b00, hs} - {2'b00, retire_eff};

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    err_d   = err_q;
    inst_d  = inst_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          step_d  = 2'd0;
          err_d   = 3'd0;
          state_d = RESP;
          if (!halted_i)
            err_d = 3'd4;
          else if (!cmd_transfer_i)
            err_d = 3'd0;
          else if ((cmd_aarsize_i != 3'd2) || !(cmd_is_csr || cmd_is_gpr))
            err_d = 3'd2;
          else begin
            state_d = ISSUE;
            inst_d  = encode(cmd_is_csr, cmd_write_i, cmd_regno_i[11:0], 2'd0);
          end
        end
      end
      ISSUE: begin
        if (hs) begin
          if (last_step)
            state_d = DRAIN;
          else begin
            step_d = step_q + 2'd1;
            inst_d = encode(is_csr_q, write_q, regno_q, step_q + 2'd1);
          end
        end
      end
      DRAIN:   if (outst_q == 3'd0) state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      step_q   <= 2'd0;
      outst_q  <= 3'd0;
      err_q    <= 3'd0;
      inst_q   <= 32'd0;
      done_q   <= 1'b0;
      cmderr_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      outst_q  <= outst_d;
      err_q    <= err_d;
      inst_q   <= inst_d;
      done_q   <= (state_q == RESP);
      cmderr_q <= (state_q == RESP) ? err_q : 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      is_csr_q <= cmd_is_csr;
      write_q  <= cmd_write_i;
      regno_q  <= cmd_regno_i[11:0];
    end
  end

endmodule

// File: tb/tb_dbg_abscmd_encoder.sv
// Bench for dbg_abscmd_encoder: directed vector table, backpressure/limit/reset
// sequences, and randomized commands against a command-level model.
module tb_dbg_abscmd_encoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        halted = 1'b0, cmd_valid = 1'b0, cmd_write = 1'b0, cmd_transfer = 1'b0;
  logic [15:0] cmd_regno = '0;
  logic [2:0]  cmd_aarsize = '0;
  logic        inst_ready = 1'b0, inst_retire = 1'b0;
  logic        cmd_ready, inst_valid, done;
  logic [31:0] inst;
  logic [2:0]  cmderr;

  logic        cmd_valid1 = 1'b0, inst_ready1 = 1'b0, inst_retire1 = 1'b0;
  logic        cmd_ready1, inst_valid1, done1;
  logic [31:0] inst1;
  logic [2:0]  cmderr1;

  dbg_abscmd_encoder dut (
    .clk(clk), .rst_n(rst_n), .halted_i(halted), .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready), .cmd_regno_i(cmd_regno), .cmd_write_i(cmd_write),
    .cmd_transfer_i(cmd_transfer), .cmd_aarsize_i(cmd_aarsize), .inst_valid_o(inst_valid),
    .inst_ready_i(inst_ready), .inst_o(inst), .inst_retire_i(inst_retire),
    .done_o(done), .cmderr_o(cmderr));

  dbg_abscmd_encoder #(.MAX_OUTSTANDING(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .halted_i(halted), .cmd_valid_i(cmd_valid1),
    .cmd_ready_o(cmd_ready1), .cmd_regno_i(cmd_regno), .cmd_write_i(cmd_write),
    .cmd_transfer_i(cmd_transfer), .cmd_aarsize_i(cmd_aarsize), .inst_valid_o(inst_valid1),
    .inst_ready_i(inst_ready1), .inst_o(inst1), .inst_retire_i(inst_retire1),
    .done_o(done1), .cmderr_o(cmderr1));

  typedef struct packed {
    logic [15:0] regno;
    logic        write;
    logic        transfer;
    logic [2:0]  aarsize;
    logic        halted;
  } cmd_t;

  typedef struct {
    cmd_t              c;
    logic [2:0]        err;
    int                n;
    logic [3:0][31:0]  inst;
  } vec_t;

  int checks = 0;
  int failures = 0;

  logic [31:0] got_q[$];
  bit got_done;
  logic [2:0] got_err;
  int done_cyc, acc_cyc, pend, pend_at_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rw(input logic [11:0] csr, input logic [4:0] rs1, input logic [4:0] rd);
    return {csr, rs1, 3'b001, rd, 7'h73};
  endfunction

  function automatic logic [31:0] rs(input logic [11:0] csr, input logic [4:0] rs1, input logic [4:0] rd);
    return {csr, rs1, 3'b010, rd, 7'h73};
  endfunction

  // Command-level reference: error code and the full instruction list for one command.
  function automatic void model(input cmd_t c, output logic [2:0] err, output int n,
                                output logic [3:0][31:0] e);
    bit is_gpr = (c.regno >= 16'h1000) && (c.regno <= 16'h101F);
    bit is_csr = (c.regno < 16'h1000);
    e = '0; n = 0; err = 3'd0;
    if (!c.halted) err = 3'd4;
    else if (!c.transfer) err = 3'd0;
    else if (c.aarsize != 3'd2 || !(is_gpr || is_csr)) err = 3'd2;
    else if (is_gpr) begin
      n = 1;
      e[0] = c.write ? rs(12'h7B2, 5'd0, c.regno[4:0]) : rw(12'h7B2, c.regno[4:0], 5'd0);
    end else begin
      n = 4;
      e[0] = rw(12'h7B3, 5'd8, 5'd0);
      e[1] = c.write ? rs(12'h7B2, 5'd0, 5'd8) : rs(c.regno[11:0], 5'd0, 5'd8);
      e[2] = c.write ? rw(c.regno[11:0], 5'd8, 5'd0) : rw(12'h7B2, 5'd8, 5'd0);
      e[3] = rs(12'h7B3, 5'd0, 5'd8);
    end
  endfunction

  function automatic vec_t mk(input logic [15:0] regno, input logic w, input logic t,
                              input logic [2:0] sz, input logic h, input logic [2:0] err,
                              input int n, input logic [31:0] i0, input logic [31:0] i1,
                              input logic [31:0] i2, input logic [31:0] i3);
    vec_t v;
    v.c = '{regno: regno, write: w, transfer: t, aarsize: sz, halted: h};
    v.err = err; v.n = n;
    v.inst[0] = i0; v.inst[1] = i1; v.inst[2] = i2; v.inst[3] = i3;
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    int sel = int'($urandom_range(0, 9));
    if (sel < 4)      v.c.regno = 16'h1000 + 16'($urandom_range(0, 31));
    else if (sel < 8) v.c.regno = 16'($urandom_range(0, 4095));
    else              v.c.regno = 16'($urandom_range(32'h1020, 32'hFFFF));
    v.c.write    = ($urandom_range(0, 1) == 1);
    v.c.transfer = ($urandom_range(0, 9) != 0);
    v.c.halted   = ($urandom_range(0, 9) != 0);
    v.c.aarsize  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
    model(v.c, v.err, v.n, v.inst);
    return v;
  endfunction

  // Drive one command and a core-side environment; stall_at/abort_at < 0 disable those.
  task automatic run_cmd(input vec_t v, input bit rnd, input int stall_at, input int abort_at);
    int cyc = 0;
    int stall_n = 0;
    bit accepted = 0;
    bit aborted = 0;
    bit issuing, hs;
    got_q.delete();
    got_done = 0; got_err = '0; done_cyc = -1; acc_cyc = -1; pend = 0; pend_at_done = -1;
    cmd_regno = v.c.regno; cmd_write = v.c.write; cmd_transfer = v.c.transfer;
    cmd_aarsize = v.c.aarsize; halted = v.c.halted;
    while (!got_done && !aborted && cyc < 300) begin
      @(negedge clk);
      cmd_valid = !accepted;
      issuing = accepted && (got_q.size() < v.n);
      if (abort_at >= 0 && got_q.size() == abort_at) begin
        rst_n = 1'b0; cmd_valid = 1'b0; inst_ready = 1'b0; inst_retire = 1'b0;
        @(posedge clk); #1;
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cmderr", 32'(cmderr), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_inst", inst, 32'd0);
        rst_n = 1'b1;
        aborted = 1;
      end else begin
        inst_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
        if (issuing && stall_at >= 0 && got_q.size() == stall_at && stall_n < 5) begin
          inst_ready = 1'b0;
          stall_n++;
        end
        inst_retire = (pend > 0) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
        #1;
        check("inst_valid", 32'(inst_valid), 32'(issuing && pend < 4));
        if (inst_valid && !inst_ready && got_q.size() < 4)
          check("inst_hold", inst, v.inst[got_q.size()]);
        hs = inst_valid && inst_ready;
        if (hs) got_q.push_back(inst);
        if (done) begin
          got_done = 1; got_err = cmderr; done_cyc = cyc; pend_at_done = pend;
        end
        if (cmd_valid && cmd_ready) begin
          accepted = 1; acc_cyc = cyc;
        end
        pend = pend + int'(hs) - int'(inst_retire);
        cyc++;
      end
    end
    cmd_valid = 1'b0; inst_ready = 1'b0; inst_retire = 1'b0;
    if (!aborted) begin
      check("done_seen", 32'(got_done), 32'd1);
      check("cmderr", 32'(got_err), 32'(v.err));
      check("n_inst", 32'(got_q.size()), 32'(v.n));
      for (int k = 0; k < got_q.size() && k < 4; k++) check("inst_seq", got_q[k], v.inst[k]);
      check("drained", 32'(pend_at_done), 32'd0);
      @(negedge clk); #1;
      check("done_pulse", {29'd0, cmderr} | 32'(done), 32'd0);
    end
  endtask

  vec_t tbl[12];

  initial begin
    int hs1, pend1;
    bit seen1;
    tbl[0]  = mk(16'h1005, 0, 1, 3'd2, 1, 3'd0, 1, 32'h7B229073, 0, 0, 0);
    tbl[1]  = mk(16'h100A, 1, 1, 3'd2, 1, 3'd0, 1, 32'h7B202573, 0, 0, 0);
    tbl[2]  = mk(16'h0300, 0, 1, 3'd2, 1, 3'd0, 4, 32'h7B341073, 32'h30002473, 32'h7B241073, 32'h7B302473);
    tbl[3]  = mk(16'h0300, 1, 1, 3'd2, 1, 3'd0, 4, 32'h7B341073, 32'h7B202473, 32'h30041073, 32'h7B302473);
    tbl[4]  = mk(16'h1005, 0, 1, 3'd3, 1, 3'd2, 0, 0, 0, 0, 0);
    tbl[5]  = mk(16'h2000, 0, 1, 3'd2, 1, 3'd2, 0, 0, 0, 0, 0);
    tbl[6]  = mk(16'h1005, 0, 1, 3'd2, 0, 3'd4, 0, 0, 0, 0, 0);
    tbl[7]  = mk(16'h1005, 0, 0, 3'd2, 1, 3'd0, 0, 0, 0, 0, 0);
    tbl[8]  = mk(16'h1000, 0, 1, 3'd2, 1, 3'd0, 1, 32'h7B201073, 0, 0, 0);
    tbl[9]  = mk(16'h0FFF, 0, 1, 3'd2, 1, 3'd0, 4, 32'h7B341073, 32'hFFF02473, 32'h7B241073, 32'h7B302473);
    tbl[10] = mk(16'h1020, 1, 1, 3'd2, 1, 3'd2, 0, 0, 0, 0, 0);
    tbl[11] = mk(16'h101F, 1, 1, 3'd2, 1, 3'd0, 1, 32'h7B202FF3, 0, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 32'(cmd_ready), 32'd1);
    check("reset_valid", 32'(inst_valid), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_cmderr", 32'(cmderr), 32'd0);
    check("reset_inst", inst, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      run_cmd(tbl[i], 1'b0, -1, -1);
      if (tbl[i].n == 0) check("err_latency", 32'(done_cyc - acc_cyc), 32'd2);
    end

    // Backpressure on the second CSR-read instruction.
    run_cmd(tbl[2], 1'b0, 1, -1);

    // Reset while the third CSR-write instruction is pending, then a clean rerun.
    run_cmd(tbl[3], 1'b0, -1, 2);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #1;
      check("no_done_after_reset", 32'(done), 32'd0);
    end
    run_cmd(tbl[3], 1'b0, -1, -1);

    // Outstanding limit of one on the second instance.
    cmd_regno = 16'h0300; cmd_write = 1'b0; cmd_transfer = 1'b1; cmd_aarsize = 3'd2; halted = 1'b1;
    @(negedge clk);
    cmd_valid1 = 1'b1; inst_ready1 = 1'b1; inst_retire1 = 1'b0;
    #1;
    check("lim_accept_ready", 32'(cmd_ready1), 32'd1);
    @(negedge clk);
    cmd_valid1 = 1'b0;
    #1;
    check("lim_first_valid", 32'(inst_valid1), 32'd1);
    check("lim_first_inst", inst1, 32'h7B341073);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      check("lim_blocked", 32'(inst_valid1), 32'd0);
    end
    @(negedge clk);
    inst_retire1 = 1'b1;
    #1;
    check("lim_blocked_retire", 32'(inst_valid1), 32'd0);
    @(negedge clk);
    inst_retire1 = 1'b0;
    #1;
    check("lim_resume_valid", 32'(inst_valid1), 32'd1);
    check("lim_resume_inst", inst1, 32'h30002473);
    hs1 = 2; pend1 = 1; seen1 = 0;
    for (int k = 0; k < 60 && !seen1; k++) begin
      @(negedge clk);
      inst_retire1 = (pend1 > 0);
      #1;
      if (done1) begin
        seen1 = 1;
        check("lim_cmderr", 32'(cmderr1), 32'd0);
      end
      pend1 = pend1 + int'(inst_valid1 && inst_ready1) - int'(inst_retire1);
      hs1 += int'(inst_valid1 && inst_ready1);
    end
    inst_ready1 = 1'b0; inst_retire1 = 1'b0;
    check("lim_done", 32'(seen1), 32'd1);
    check("lim_inst_count", 32'(hs1), 32'd4);

    for (int r = 0; r < 60; r++) run_cmd(rand_vec(), 1'b1, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
